b_preadd_cascade: RTL and testbench

B_PREADD_CASCADE -- requirements
Module: b_preadd_cascade

---
 rtl/b_preadd_cascade_if.sv | 22 ++
 rtl/b_preadd_cascade.sv | 78 +++++++
 tb/tb_b_preadd_cascade.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/b_preadd_cascade_if.sv
// rtl/b_preadd_cascade_if.sv - operand, control and result bundle for the B pre-adder slice
interface b_preadd_cascade_if;
    logic [17:0] B;
    logic [17:0] BCIN;
    logic [17:0] D;
    logic [1:0]  OPMODE;
    logic        CEB;
    logic        CED;
    logic        CEOPMODE;
    logic [17:0] B1_OUT;
    logic [17:0] BCOUT;

    modport master (
        output B, BCIN, D, OPMODE, CEB, CED, CEOPMODE,
        input  B1_OUT, BCOUT
    );

    modport slave (
        input  B, BCIN, D, OPMODE, CEB, CED, CEOPMODE,
        output B1_OUT, BCOUT
    );
endinterface

// File: rtl/b_preadd_cascade.sv
// rtl/b_preadd_cascade.sv - B operand select, optional B0/D/OPMODE regs, pre-adder and B1 stage
module b_preadd_cascade #(
    parameter int    B0REG     = 0,
    parameter int    B1REG     = 1,
    parameter int    DREG      = 1,
    parameter int    OPMODEREG = 1,
    parameter string B_INPUT   = "DIRECT"
) (
    input  logic              CLK,
    input  logic              RSTB,
    b_preadd_cascade_if.slave bus
);

    localparam logic [1:0] SEL_DIRECT  = 2'd0;
    localparam logic [1:0] SEL_CASCADE = 2'd1;
    localparam logic [1:0] SEL_ZERO    = 2'd2;
    localparam logic [1:0] B_SEL_MODE  = (B_INPUT == "DIRECT")  ? SEL_DIRECT  :
                                         (B_INPUT == "CASCADE") ? SEL_CASCADE : SEL_ZERO;

    logic [17:0] b_sel;
    logic [17:0] b0;
    logic [17:0] d0;
    logic [1:0]  op;
    logic [17:0] pa;
    logic [17:0] b1;

    logic [17:0] b0_q, b0_d;
    logic [17:0] d_q,  d_d;
    logic [1:0]  op_q, op_d;
    logic [17:0] b1_q, b1_d;

    always_comb begin
        b_sel = 18'h0;
        case (B_SEL_MODE)
            SEL_DIRECT:  b_sel = bus.B;
            SEL_CASCADE: b_sel = bus.BCIN;
            default:     b_sel = 18'h0;
        endcase
    end

    // Registers always exist; a zero parameter simply bypasses them, so
    // combinational stages never see RSTB.
    assign b0 = (B0REG     != 0) ? b0_q : b_sel;
    assign d0 = (DREG      != 0) ? d_q  : bus.D;
    assign op = (OPMODEREG != 0) ? op_q : bus.OPMODE;

    always_comb begin
        pa = b0;
        if (op[0]) begin
            pa = op[1] ? (d0 - b0) : (d0 + b0);
        end
    end

    // B0 and B1 share CEB, so B1 captures pa built from the pre-edge b0.
    assign b0_d = bus.CEB      ? b_sel      : b0_q;
    assign d_d  = bus.CED      ? bus.D      : d_q;
    assign op_d = bus.CEOPMODE ? bus.OPMODE : op_q;
    assign b1_d = bus.CEB      ? pa         : b1_q;

    always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
            b0_q <= 18'h0;
            d_q  <= 18'h0;
            op_q <= 2'b00;
            b1_q <= 18'h0;
        end else begin
            b0_q <= b0_d;
            d_q  <= d_d;
            op_q <= op_d;
            b1_q <= b1_d;
        end
    end

    assign b1         = (B1REG != 0) ? b1_q : pa;
    assign bus.B1_OUT = b1;
    assign bus.BCOUT  = b1;

endmodule

// File: tb/tb_b_preadd_cascade.sv
// tb/tb_b_preadd_cascade.sv - directed-vector bench with a behavioural pre-adder model
module tb_b_preadd_cascade;

    logic CLK  = 1'b0;
    logic RSTB = 1'b1;
    always #5 CLK = ~CLK;

    logic [17:0] b      = 18'h0;
    logic [17:0] bcin   = 18'h0;
    logic [17:0] d      = 18'h0;
    logic [1:0]  opmode = 2'b00;
    logic        ceb    = 1'b1;
    logic        ced    = 1'b1;
    logic        ceop   = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // 0: defaults, 1: CASCADE, 2: all stages combinational, 3: B0 and B1 registered
    localparam int P_B0  [4] = '{0, 0, 0, 1};
    localparam int P_B1  [4] = '{1, 1, 0, 1};
    localparam int P_D   [4] = '{1, 1, 0, 1};
    localparam int P_OP  [4] = '{1, 1, 0, 1};
    localparam int P_CAS [4] = '{0, 1, 0, 0};

    b_preadd_cascade_if ifc [4] ();
    logic [17:0] out_b1 [4];
    logic [17:0] out_bc [4];

    for (genvar g = 0; g < 4; g++) begin : g_drv
        assign ifc[g].B        = b;
        assign ifc[g].BCIN     = bcin;
        assign ifc[g].D        = d;
        assign ifc[g].OPMODE   = opmode;
        assign ifc[g].CEB      = ceb;
        assign ifc[g].CED      = ced;
        assign ifc[g].CEOPMODE = ceop;
        assign out_b1[g]       = ifc[g].B1_OUT;
        assign out_bc[g]       = ifc[g].BCOUT;
    end

    b_preadd_cascade u_def (.CLK(CLK), .RSTB(RSTB), .bus(ifc[0]));
    b_preadd_cascade #(.B_INPUT("CASCADE")) u_cas (.CLK(CLK), .RSTB(RSTB), .bus(ifc[1]));
    b_preadd_cascade #(.B0REG(0), .B1REG(0), .DREG(0), .OPMODEREG(0)) u_comb (.CLK(CLK), .RSTB(RSTB), .bus(ifc[2]));
    b_preadd_cascade #(.B0REG(1)) u_b0r (.CLK(CLK), .RSTB(RSTB), .bus(ifc[3]));

    logic [17:0] mb0 [4] = '{default: 18'h0};
    logic [17:0] md  [4] = '{default: 18'h0};
    logic [1:0]  mop [4] = '{default: 2'b00};
    logic [17:0] mb1 [4] = '{default: 18'h0};

    function automatic logic [17:0] pre(logic [17:0] dv, logic [17:0] bv, logic [1:0] o);
        int r;
        if (!o[0])     r = int'(bv);
        else if (o[1]) r = int'(dv) - int'(bv);
        else           r = int'(dv) + int'(bv);
        r = ((r % 262144) + 262144) % 262144;
        return r[17:0];
    endfunction

    function automatic logic [17:0] m_bsel(int i);
        return (P_CAS[i] != 0) ? bcin : b;
    endfunction

    function automatic logic [17:0] m_pa(int i);
        logic [17:0] bv;
        logic [17:0] dv;
        logic [1:0]  ov;
        bv = (P_B0[i] != 0) ? mb0[i] : m_bsel(i);
        dv = (P_D[i]  != 0) ? md[i]  : d;
        ov = (P_OP[i] != 0) ? mop[i] : opmode;
        return pre(dv, bv, ov);
    endfunction

    function automatic logic [17:0] m_out(int i);
        return (P_B1[i] != 0) ? mb1[i] : m_pa(i);
    endfunction

    always @(posedge CLK or posedge RSTB) begin
        for (int i = 0; i < 4; i++) begin
            if (RSTB) begin
                mb0[i] <= 18'h0;
                md[i]  <= 18'h0;
                mop[i] <= 2'b00;
                mb1[i] <= 18'h0;
            end else begin
                if (ceb)  mb0[i] <= m_bsel(i);
                if (ced)  md[i]  <= d;
                if (ceop) mop[i] <= opmode;
                if (ceb)  mb1[i] <= m_pa(i);
            end
        end
    end

    task automatic check(string nm, logic [17:0] act, logic [17:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("model_b1[%0d]", i), out_b1[i], m_out(i));
                check($sformatf("model_bc[%0d]", i), out_bc[i], m_out(i));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [17:0] hold_vals [3] = '{18'h00009, 18'h00020, 18'h00033};

    initial begin
        repeat (2) tick();
        check("rst_def_b1", out_b1[0], 18'h0);
        check("rst_def_bc", out_bc[0], 18'h0);
        check("rst_cas_b1", out_b1[1], 18'h0);
        check("rst_b0r_b1", out_b1[3], 18'h0);
        cmp_en = 1'b1;

        b = 18'd7; d = 18'd3; opmode = 2'b11;
        #1;
        check("comb_sub_wrap", out_b1[2], 18'h3FFFC);
        check("comb_sub_wrap_bc", out_bc[2], 18'h3FFFC);

        RSTB = 1'b0;
        b = 18'h00005; d = 18'h00010; opmode = 2'b01; bcin = 18'h00ABC;
        #1;
        check("comb_add", out_b1[2], 18'h00015);
        tick();
        check("def_edge1_not_yet", out_b1[0], 18'h00005);
        check("b0r_edge1", out_b1[3], 18'h00000);
        tick();
        check("def_edge2", out_b1[0], 18'h00015);
        check("def_edge2_bc", out_bc[0], 18'h00015);
        check("b0r_edge2", out_b1[3], 18'h00015);
        check("cas_edge2", out_b1[1], 18'h00ACC);

        ceb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b = hold_vals[k];
            tick();
            check($sformatf("ceb_hold_%0d", k), out_b1[0], 18'h00015);
        end
        ceb = 1'b1;
        tick();
        check("ceb_resume", out_b1[0], 18'h00043);

        opmode = 2'b11; d = 18'h0; b = 18'h1;
        repeat (2) tick();
        check("sub_wrap", out_b1[0], 18'h3FFFF);
        opmode = 2'b01; d = 18'h3FFFF; b = 18'h1;
        repeat (2) tick();
        check("add_wrap", out_b1[0], 18'h00000);

        opmode = 2'b00;
        tick();
        b = 18'h12345; bcin = 18'h00ABC;
        tick();
        check("cascade_sel", out_b1[1], 18'h00ABC);
        check("direct_sel", out_b1[0], 18'h12345);

        @(posedge CLK);
        #3 RSTB = 1'b1;
        #1;
        check("midrst_def", out_b1[0], 18'h0);
        check("midrst_cas", out_b1[1], 18'h0);
        check("midrst_b0r", out_b1[3], 18'h0);
        b = 18'd7; d = 18'd3; opmode = 2'b01;
        #2 RSTB = 1'b0;
        tick();
        check("post_rst_edge1", out_b1[0], 18'h00007);
        tick();
        check("post_rst_edge2", out_b1[0], 18'h0000A);

        repeat (2) tick();
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
